// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial receive control path.
package serial_pkg;

  // Receive FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Level of the serial line when nothing is being sent.
  localparam logic RX_IDLE_LEVEL = 1'b1;

  // Default oversampling ratio and frame width.
  localparam int DEF_CLKS_PER_BIT = 4;
  localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with a configurable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/serial_rx_ctrl.sv
// Oversampling UART-style receiver that steers a downstream right-shifting
// register (serial input at the MSB) and also forwards parallel-load requests.
module serial_rx_ctrl
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 ld_req,
  input  logic [DATA_BITS-1:0] ld_val,
  output logic                 shift_load,
  output logic [DATA_BITS-1:0] shift_data,
  output logic                 shift_en,
  output logic                 shift_in,
  output logic                 byte_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_END  = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_r;
  logic [TICK_W-1:0]    tick_cnt_r;
  logic [BIT_W-1:0]     bit_idx_r;
  logic                 shift_load_r;
  logic [DATA_BITS-1:0] shift_data_r;
  logic                 shift_en_r;
  logic                 shift_in_r;
  logic                 byte_valid_r;
  logic                 frame_err_r;
  logic                 busy_r;

  sync_2ff #(
    .RESET_VAL (RX_IDLE_LEVEL)
  ) u_rx_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Receive FSM with inline counters; every output is a registered strobe
  // or a held value, pulses default low each cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      tick_cnt_r   <= TICK_ZERO;
      bit_idx_r    <= BIT_ZERO;
      shift_load_r <= 1'b0;
      shift_data_r <= {DATA_BITS{1'b0}};
      shift_en_r   <= 1'b0;
      shift_in_r   <= 1'b0;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      shift_load_r <= 1'b0;
      shift_en_r   <= 1'b0;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          tick_cnt_r <= TICK_ZERO;
          bit_idx_r  <= BIT_ZERO;
          // The first shift is at least a full bit time away, so a load
          // issued together with a start detection cannot collide with it.
          if (ld_req) begin
            shift_load_r <= 1'b1;
            shift_data_r <= ld_val;
          end
          if (rx_s != RX_IDLE_LEVEL) begin
            state_r <= START;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          if (tick_cnt_r == TICK_MID) begin
            tick_cnt_r <= TICK_ZERO;
            if (rx_s != RX_IDLE_LEVEL) begin
              state_r <= DATA;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            tick_cnt_r <= tick_cnt_r + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_cnt_r == TICK_END) begin
            tick_cnt_r <= TICK_ZERO;
            shift_en_r <= 1'b1;
            shift_in_r <= rx_s;
            bit_idx_r  <= bit_idx_r + BIT_ONE;
            if (bit_idx_r == BIT_LAST) begin
              state_r <= STOP;
            end
          end else begin
            tick_cnt_r <= tick_cnt_r + TICK_ONE;
          end
        end
        STOP: begin
          if (tick_cnt_r == TICK_END) begin
            tick_cnt_r <= TICK_ZERO;
            bit_idx_r  <= BIT_ZERO;
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            // Register keeps whatever was shifted in even on a bad stop bit.
            if (rx_s == RX_IDLE_LEVEL) begin
              byte_valid_r <= 1'b1;
            end else begin
              frame_err_r  <= 1'b1;
            end
          end else begin
            tick_cnt_r <= tick_cnt_r + TICK_ONE;
          end
        end
        default: begin
          state_r    <= IDLE;
          tick_cnt_r <= TICK_ZERO;
          bit_idx_r  <= BIT_ZERO;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign shift_load = shift_load_r;
  assign shift_data = shift_data_r;
  assign shift_en   = shift_en_r;
  assign shift_in   = shift_in_r;
  assign byte_valid = byte_valid_r;
  assign frame_err  = frame_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Directed, table-driven bench for serial_rx_ctrl with a model of the
// downstream right-shifting register.
module tb_serial_rx_ctrl;

  localparam int CPB  = 4;
  localparam int HALF = CPB / 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       ld_req;
  logic [7:0] ld_val;
  logic       shift_load;
  logic [7:0] shift_data;
  logic       shift_en;
  logic       shift_in;
  logic       byte_valid;
  logic       frame_err;
  logic       busy;

  serial_rx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .ld_req     (ld_req),
    .ld_val     (ld_val),
    .shift_load (shift_load),
    .shift_data (shift_data),
    .shift_en   (shift_en),
    .shift_in   (shift_in),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Monitor state
  logic [7:0] reg_model = 8'h00;
  logic [7:0] hist;
  logic [7:0] vals [0:3];
  int shift_cnt, valid_cnt, err_cnt, load_cnt;
  int spacing_bad, overlap_bad = 0;
  int busy_run, busy_max;
  int mon_cyc = 0;
  int last_shift;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_reg;
  } vec_t;

  vec_t vecs [0:4];

  // Downstream register model and event counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (shift_en && shift_load) overlap_bad++;
    if (byte_valid && frame_err) overlap_bad++;
    if (shift_load) begin
      reg_model = shift_data;
      load_cnt++;
    end else if (shift_en) begin
      reg_model = {shift_in, reg_model[7:1]};
      if (shift_cnt < 8) hist[shift_cnt] = shift_in;
      if (shift_cnt > 0 && (mon_cyc - last_shift) != CPB) spacing_bad++;
      last_shift = mon_cyc;
      shift_cnt++;
    end
    if (byte_valid) begin
      if (valid_cnt < 4) vals[valid_cnt] = reg_model;
      valid_cnt++;
    end
    if (frame_err) err_cnt++;
    if (busy) begin
      busy_run++;
      if (busy_run > busy_max) busy_max = busy_run;
    end else begin
      busy_run = 0;
    end
    mon_cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    shift_cnt   = 0;
    valid_cnt   = 0;
    err_cnt     = 0;
    load_cnt    = 0;
    spacing_bad = 0;
    busy_run    = 0;
    busy_max    = 0;
    hist        = 8'h00;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drive one full frame; optionally pulse ld_req=0xFF at the start of bit ld_at.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int ld_at);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      for (int c = 0; c < CPB; c++) begin
        if (b == ld_at && c == 0) begin
          ld_req = 1'b1;
          ld_val = 8'hFF;
        end else begin
          ld_req = 1'b0;
        end
        tick(1);
      end
    end
    ld_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] pbits;
    clear_mon();
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'h3C};
    vecs[2] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b0, 0, 1, 8'hFF};

    reset  = 1'b1;
    rx     = 1'b1;
    ld_req = 1'b0;
    ld_val = 8'h00;
    tick(3);
    check("reset_outputs", {18'd0, shift_load, shift_data, shift_en, shift_in, byte_valid, frame_err},
          32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick(4);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      clear_mon();
      send_frame(vecs[v].data, vecs[v].stop, -1);
      rx = 1'b1;
      tick(12);
      check($sformatf("v%0d_shifts", v), shift_cnt, 8);
      check($sformatf("v%0d_valid", v), valid_cnt, vecs[v].exp_valid);
      check($sformatf("v%0d_ferr", v), err_cnt, vecs[v].exp_err);
      check($sformatf("v%0d_reg", v), {24'd0, reg_model}, {24'd0, vecs[v].exp_reg});
      check($sformatf("v%0d_shift_in_seq", v), {24'd0, hist}, {24'd0, vecs[v].data});
      check($sformatf("v%0d_spacing", v), spacing_bad, 0);
      check($sformatf("v%0d_busy_idle", v), {31'd0, busy}, 32'd0);
    end

    // One-cycle glitch on rx: false start
    clear_mon();
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(20);
    check("glitch_shifts", shift_cnt, 0);
    check("glitch_valid", valid_cnt, 0);
    check("glitch_ferr", err_cnt, 0);
    check("glitch_busy_seen", {31'd0, busy_max >= 1}, 32'd1);
    check("glitch_busy_len", {31'd0, busy_max <= HALF + 1}, 32'd1);

    // Reset after the third shift_en of a frame
    clear_mon();
    pbits = {1'b1, 8'h55, 1'b0};
    for (int c = 0; c < 10 * CPB && shift_cnt < 3; c++) begin
      rx = pbits[c / CPB];
      tick(1);
    end
    check("midrst_reach", shift_cnt, 3);
    reset = 1'b1;
    rx    = 1'b1;
    tick(1);
    check("midrst_outputs", {18'd0, shift_load, shift_data, shift_en, shift_in, byte_valid, frame_err},
          32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick(4);
    clear_mon();
    send_frame(8'h81, 1'b1, -1);
    rx = 1'b1;
    tick(12);
    check("after_rst_valid", valid_cnt, 1);
    check("after_rst_reg", {24'd0, vals[0]}, 32'h81);

    // Parallel load accepted in IDLE
    clear_mon();
    ld_req = 1'b1;
    ld_val = 8'h5A;
    tick(1);
    ld_req = 1'b0;
    check("load_strobe", {31'd0, shift_load}, 32'd1);
    check("load_data", {24'd0, shift_data}, 32'h5A);
    tick(1);
    check("load_strobe_off", {31'd0, shift_load}, 32'd0);
    check("load_data_hold", {24'd0, shift_data}, 32'h5A);
    check("load_count", load_cnt, 1);
    check("load_reg", {24'd0, reg_model}, 32'h5A);

    // Load request during DATA is dropped
    clear_mon();
    send_frame(8'h96, 1'b1, 4);
    rx = 1'b1;
    tick(12);
    check("busy_load_dropped", load_cnt, 0);
    check("busy_load_valid", valid_cnt, 1);
    check("busy_load_reg", {24'd0, vals[0]}, 32'h96);
    check("busy_load_data_hold", {24'd0, shift_data}, 32'h5A);

    // Back-to-back frames, no idle gap
    clear_mon();
    send_frame(8'h01, 1'b1, -1);
    send_frame(8'hFE, 1'b1, -1);
    rx = 1'b1;
    tick(12);
    check("b2b_valid", valid_cnt, 2);
    check("b2b_ferr", err_cnt, 0);
    check("b2b_first", {24'd0, vals[0]}, 32'h01);
    check("b2b_second", {24'd0, vals[1]}, 32'hFE);
    check("b2b_spacing_shifts", shift_cnt, 16);

    check("exclusive_strobes", overlap_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
